// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Defines the lock FSM states and the end-of-message byte values.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] EOM_LF  = 8'h0A;
  localparam logic [7:0] EOM_EOT = 8'h04;
  localparam int         TCNT_W  = 8;

  function automatic logic is_eom(input logic [7:0] b);
    return (b == EOM_LF) || (b == EOM_EOT);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_i+1 with wrap-around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    // Offsets 1..N visit every requester once, ending on last_i itself.
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(last_i) + off) % N);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX byte interface among NREQ requesters with message-level
// round-robin locking, released on LF/EOT or after TIMEOUT silent cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [8*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]   REQ_READY,
  output logic              TX_VALID,
  output logic [7:0]        TX_DATA,
  input  logic              TX_READY,
  output logic              BUSY,
  output logic [IDW-1:0]    GRANT_ID,
  output logic              DBG_STATE,
  output logic [TCNT_W-1:0] DBG_TCNT
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  // Handshake: a byte moves on a side in any cycle where its valid and ready
  // are both 1; valid/data are held stable by the source until then.
  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    last_q,  last_d;
  logic [TCNT_W-1:0] tcnt_q,  tcnt_d;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           own_valid;
  logic [7:0]     own_data;
  logic           xfer;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req_i  (REQ_VALID),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  assign own_valid = REQ_VALID[owner_q];
  assign own_data  = REQ_DATA[owner_q*8 +: 8];
  assign xfer      = (state_q == LOCKED) && own_valid && TX_READY;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCKED;
          owner_d = pick_idx;
          tcnt_d  = '0;
        end
      end
      LOCKED: begin
        // A transfer means the owner is valid, so EOM and timeout are exclusive.
        if (xfer) begin
          tcnt_d = '0;
          if (is_eom(own_data)) begin
            state_d = IDLE;
            last_d  = owner_q;
            owner_d = '0;
          end
        end else if (!own_valid) begin
          if (tcnt_q == TCNT_LAST) begin
            state_d = IDLE;
            last_d  = owner_q;
            owner_d = '0;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TX_VALID  = 1'b0;
    TX_DATA   = 8'h00;
    REQ_READY = '0;
    if (state_q == LOCKED) begin
      TX_VALID           = own_valid;
      TX_DATA            = own_data;
      REQ_READY[owner_q] = TX_READY;
    end
  end

  // owner_q is cleared on release, so both are pure register outputs.
  assign BUSY      = (state_q == LOCKED);
  assign GRANT_ID  = owner_q;
  assign DBG_STATE = state_q;
  assign DBG_TCNT  = tcnt_q;

endmodule
